// File: rtl/match_filter_param.sv
// NTAPS-long +/-1 I/Q correlator with thresholded match pulse and post-match holdoff.
// Optional MATCH_FILTER_PARAM_TIMESTAMP_EN adds match_time, the strobe count of the matching sample.
module match_filter_param #(
    parameter int IN_W    = 16,
    parameter int NTAPS   = 64,
    parameter int CADDR_W = 3,
    parameter int HOLDOFF = 16,
    localparam int METRIC_W = IN_W + $clog2(NTAPS) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic signed [IN_W-1:0]     r_input,
    input  logic signed [IN_W-1:0]     i_input,
    input  logic                       rxstrobe,
    input  logic                       cwrite,
    input  logic [CADDR_W-1:0]         caddr,
    input  logic [31:0]                cdata,
    output logic                       valid,
    output logic                       match,
    output logic [METRIC_W-1:0]        metric
`ifdef MATCH_FILTER_PARAM_TIMESTAMP_EN
    ,
    output logic [31:0]                match_time
`endif
);

    localparam int ACC_W  = IN_W + $clog2(NTAPS);
    localparam int NWORDS = NTAPS / 32;
    localparam int FW     = $clog2(NTAPS) + 1;
    localparam int HW     = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [CADDR_W-1:0] THR_ADDR = CADDR_W'(NWORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]              state;
    logic [FW-1:0]           fill;
    logic [HW-1:0]           hcnt;
    logic                    pend;
    logic [NTAPS-1:0]        coef;
    logic [METRIC_W-1:0]     thr;
    logic signed [IN_W-1:0]  win_i [NTAPS];
    logic signed [IN_W-1:0]  win_q [NTAPS];

    logic signed [ACC_W-1:0] corr_i, corr_q;
    logic [ACC_W-1:0]        abs_i, abs_q;
    logic [METRIC_W-1:0]     metric_next;
    logic                    coef_wr, thr_wr, kill, hit;

    assign coef_wr = cwrite && (caddr < THR_ADDR);
    assign thr_wr  = cwrite && (caddr == THR_ADDR);
    assign kill    = !enable || (coef_wr && state != S_IDLE);
    assign hit     = pend && !kill && state == S_RUN && metric_next >= thr;

    // Operands are sign-extended to ACC_W before negation so -2^(IN_W-1) stays exact.
    always_comb begin
        corr_i = '0;
        corr_q = '0;
        for (int unsigned k = 0; k < NTAPS; k++) begin
            if (coef[k]) begin
                corr_i = corr_i + ACC_W'(win_i[k]);
                corr_q = corr_q + ACC_W'(win_q[k]);
            end else begin
                corr_i = corr_i - ACC_W'(win_i[k]);
                corr_q = corr_q - ACC_W'(win_q[k]);
            end
        end
        abs_i       = corr_i[ACC_W-1] ? ACC_W'(-corr_i) : ACC_W'(corr_i);
        abs_q       = corr_q[ACC_W-1] ? ACC_W'(-corr_q) : ACC_W'(corr_q);
        metric_next = METRIC_W'(abs_i) + METRIC_W'(abs_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NTAPS; k++) begin
                win_i[k] <= '0;
                win_q[k] <= '0;
            end
        end else if (rxstrobe) begin
            win_i[0] <= r_input;
            win_q[0] <= i_input;
            for (int unsigned k = 1; k < NTAPS; k++) begin
                win_i[k] <= win_i[k-1];
                win_q[k] <= win_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coef <= '0;
            thr  <= '1;
        end else begin
            if (thr_wr) thr <= cdata[METRIC_W-1:0];
            for (int unsigned w = 0; w < NWORDS; w++) begin
                if (coef_wr && caddr == CADDR_W'(w)) coef[32*w +: 32] <= cdata;
            end
        end
    end

    // pend marks a window sample awaiting evaluation; RUN/HOLD decisions happen at that
    // evaluation edge so holdoff tracks back-to-back strobes correctly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            fill   <= '0;
            hcnt   <= '0;
            pend   <= 1'b0;
            valid  <= 1'b0;
            match  <= 1'b0;
            metric <= '0;
        end else begin
            valid <= 1'b0;
            match <= 1'b0;
            if (kill) begin
                state <= enable ? S_FILL : S_IDLE;
                fill  <= '0;
                hcnt  <= '0;
                pend  <= 1'b0;
            end else begin
                pend <= 1'b0;
                if (pend) begin
                    valid  <= 1'b1;
                    metric <= metric_next;
                    if (hit) begin
                        match <= 1'b1;
                        if (HOLDOFF > 0) begin
                            state <= S_HOLD;
                            hcnt  <= HW'(HOLDOFF);
                        end
                    end else if (state == S_HOLD) begin
                        if (hcnt <= HW'(1)) begin
                            state <= S_RUN;
                            hcnt  <= '0;
                        end else begin
                            hcnt <= hcnt - HW'(1);
                        end
                    end
                end
                case (state)
                    S_IDLE: begin
                        state <= S_FILL;
                        fill  <= '0;
                    end
                    S_FILL: begin
                        if (rxstrobe) begin
                            if (fill == FW'(NTAPS - 1)) begin
                                state <= S_RUN;
                                fill  <= '0;
                                pend  <= 1'b1;
                            end else begin
                                fill <= fill + FW'(1);
                            end
                        end
                    end
                    default: begin
                        if (rxstrobe) pend <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef MATCH_FILTER_PARAM_TIMESTAMP_EN
    logic [31:0] ts_cnt, ts_pend;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_cnt     <= '0;
            ts_pend    <= '0;
            match_time <= '0;
        end else begin
            if (rxstrobe) begin
                ts_cnt  <= ts_cnt + 32'd1;
                ts_pend <= ts_cnt + 32'd1;
            end
            if (hit) match_time <= ts_pend;
        end
    end
`endif

endmodule
